imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory. It accepts a byte stream (valid/ready) carrying a length header, little-endian instruction words and an XOR checksum. It assembles each word and drives the instruction memory's write port (`write`, `addr_in`, `data`). The CPU core is held in reset until a complete, checksum-correct image has been written.

## Interface
- `DEPTH`, default 128: instruction memory size in 32-bit words.
- `START_WORD`, default 0: word index written by the first payload word.

- `clk`: input, 1 bit. Single clock, shared with the instruction memory.
- `reset`: input, 1 bit. Synchronous, active-high. Restarts the loader from the header.
- `rx_data`: input, 8 bits. Stream byte.
- `rx_valid`: input, 1 bit. `rx_data` is valid this cycle.
- `rx_ready`: output, 1 bit. Loader accepts a byte this cycle. Combinational from state only; never depends on `rx_valid`.
- `write`: output, 1 bit. Registered one-cycle write strobe to the instruction memory.
- `addr_in`: output, 32 bits. Registered word index into the instruction memory (not a byte address).
- `data`: output, 32 bits. Registered instruction word.
- `cpu_reset`: output, 1 bit. Registered. Holds the core in reset while high.
- `done`: output, 1 bit. Registered. Image loaded and verified.
- `error`: output, 1 bit. Registered. Load rejected (oversize or checksum mismatch).

## Operation
- **Handshake:**
  - A byte is accepted on a rising edge where `rx_valid && rx_ready`.
  - Gaps in `rx_valid` are allowed anywhere; state holds while no byte is accepted.
- **States:** HDR0 → HDR1 → PAYLOAD → CSUM → DONE, or → ERROR.
  - HDR0: accept the low byte of `len` (16-bit word count).
  - HDR1: accept the high byte of `len`.
    - `len == 0`: go to CSUM.
    - `len > DEPTH - START_WORD`: go to ERROR.
    - Otherwise: go to PAYLOAD.
  - PAYLOAD: bytes are little-endian. Byte 0 goes to [7:0], through byte 3 to [31:24].
    - A 2-bit byte counter wraps 3→0.
    - On accepting byte 3 of word n (n counts from 0):
      - register `write=1`, `addr_in=START_WORD+n`, `data=assembled word`;
      - increment the word count.
    - When n equals `len-1`, go to CSUM on that same edge.
  - CSUM: accept one byte.
    - Equal to the XOR of all payload bytes (header excluded; 0x00 for empty payload): go to DONE.
    - Otherwise: go to ERROR.
  - DONE and ERROR: `rx_ready=0`. The state is terminal until `reset`.
- `rx_ready=1` in HDR0, HDR1, PAYLOAD and CSUM.
- Words already written before an ERROR remain in memory; `cpu_reset` stays high.
- **Arithmetic:**
  - The word count is 16 bits.
  - The oversize check uses unsigned compare at 32 bits; no wrap.
  - `addr_in` upper bits are zero.

## Timing
- **Reset values** (while `reset` is high and on the edge it is sampled):
  - state = HDR0, counters = 0, checksum accumulator = 0;
  - `write=0`, `addr_in=0`, `data=0`;
  - `cpu_reset=1`, `done=0`, `error=0`.
- **Write latency:** `write` is high during the cycle immediately after the edge that accepted byte 3 of a word. It is high for exactly one cycle.
  - Words need at least 4 accepted bytes each, so writes never occur back-to-back.
  - `addr_in`/`data` hold their last values when `write=0`.
- **Completion and error outputs:**
  - `done=1` and `cpu_reset=0` from the cycle after the edge accepting a matching checksum byte.
  - `error=1` from the cycle after the edge detecting the error (HDR1 oversize, or a checksum mismatch).
  - `done` and `error` are never both high.
- The final word's `write` pulse always precedes the checksum-acceptance edge, since the checksum byte needs its own accept edge.
- **Mid-load reset:** `reset` asserted at any point, including during a `write` cycle, forces all reset values on that edge.
  - A pending write is dropped: `write=0` on the following cycle.
  - A new load then starts from HDR0.
- `reset` has priority over a simultaneous byte accept.

## Test plan
- **Normal load, no gaps:** with defaults, stream 02 00 13 00 00 00 B7 07 00 00 A3.
  - Two write pulses: (`addr_in=0`, `data=0x00000013`), then (1, 0x000007B7), each one cycle after the 4th byte of its word.
  - Then `done=1`, `cpu_reset=0`, `rx_ready=0`.
- **Same stream with random `rx_valid` gaps and `START_WORD=1`:** identical data, written at `addr_in` 1 and 2; no extra or duplicate write pulses.
- **Empty image:** stream 00 00 00.
  - No write pulses; `done=1`.
  - Variant 00 00 5A gives `error=1` and `cpu_reset=1`.
- **Oversize:** stream 81 00 (129 words, DEPTH=128).
  - `error=1` the cycle after the second byte.
  - `rx_ready=0` thereafter; no writes for further bytes.
- **Checksum mismatch:** the normal-load stream with last byte A2.
  - Both writes still occur; then `error=1`, `done=0`, `cpu_reset=1`.
- **Reset mid-payload:** assert `reset` one cycle after the 6th byte of the normal-load stream, then replay the full stream.
  - Outputs return to reset values.
  - The replayed load produces exactly the normal-load write sequence and `done=1`.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
//============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream input and instruction-memory write port of the
//            boot loader, plus its status outputs.
// Revision : 1.0
//============================================================================
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        write;
    logic [31:0] addr_in;
    logic [31:0] data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    // master: the loader itself; slave: stream source / memory / core side
    modport master (
        input  rx_data, rx_valid,
        output rx_ready, write, addr_in, data, cpu_reset, done, error
    );
    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, write, addr_in, data, cpu_reset, done, error
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
//============================================================================
// Module   : imem_loader
// Brief    : Boot loader: header / little-endian words / XOR checksum stream
//            into instruction-memory writes; releases the core on success.
// Revision : 1.0
//============================================================================
module imem_loader #(
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned START_WORD = 0
) (
    input  wire           clk,
    input  wire           reset,
    imem_loader_if.master bus
);

    localparam logic [2:0] c_ST_HDR0    = 3'd0;
    localparam logic [2:0] c_ST_HDR1    = 3'd1;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
    localparam logic [2:0] c_ST_CSUM    = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;
    localparam logic [2:0] c_ST_ERROR   = 3'd5;

    // Room left in memory above START_WORD; a start beyond the end leaves none.
    localparam logic [31:0] c_CAPACITY = (START_WORD >= DEPTH) ? 32'd0 : 32'(DEPTH - START_WORD);
    localparam logic [31:0] c_START    = 32'(START_WORD);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        w_rx_ready;
    logic        w_accept;
    logic [15:0] w_len_full;
    logic        w_oversize;
    logic        w_last_word;

    logic [15:0] r_len;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_word_cnt;
    logic [7:0]  r_csum;
    logic [23:0] r_word;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_cpu_reset;
    logic        r_done;
    logic        r_error;

    assign w_len_full  = {bus.rx_data, r_len[7:0]};
    assign w_oversize  = ({16'd0, w_len_full} > c_CAPACITY);
    assign w_last_word = (r_byte_cnt == 2'd3) && (16'(r_word_cnt + 16'd1) == r_len);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_HDR0;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            case (r_state)
                c_ST_HDR0: w_next_state = c_ST_HDR1;
                c_ST_HDR1: begin
                    if (w_len_full == 16'd0) begin
                        w_next_state = c_ST_CSUM;
                    end else if (w_oversize) begin
                        w_next_state = c_ST_ERROR;
                    end else begin
                        w_next_state = c_ST_PAYLOAD;
                    end
                end
                c_ST_PAYLOAD: begin
                    if (w_last_word) begin
                        w_next_state = c_ST_CSUM;
                    end
                end
                c_ST_CSUM: w_next_state = (bus.rx_data == r_csum) ? c_ST_DONE : c_ST_ERROR;
                default: w_next_state = r_state;
            endcase
        end
    end

    // rx_ready depends on state only, never on rx_valid
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            c_ST_HDR0, c_ST_HDR1, c_ST_PAYLOAD, c_ST_CSUM: w_rx_ready = 1'b1;
            default: w_rx_ready = 1'b0;
        endcase
        w_accept = bus.rx_valid && w_rx_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len       <= 16'd0;
            r_byte_cnt  <= 2'd0;
            r_word_cnt  <= 16'd0;
            r_csum      <= 8'd0;
            r_word      <= 24'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_write     <= 1'b0;
            r_done      <= (w_next_state == c_ST_DONE);
            r_error     <= (w_next_state == c_ST_ERROR);
            r_cpu_reset <= (w_next_state != c_ST_DONE);
            if (w_accept) begin
                case (r_state)
                    c_ST_HDR0: r_len[7:0]  <= bus.rx_data;
                    c_ST_HDR1: r_len[15:8] <= bus.rx_data;
                    c_ST_PAYLOAD: begin
                        r_csum     <= r_csum ^ bus.rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            default: begin
                                r_write    <= 1'b1;
                                r_addr     <= c_START + {16'd0, r_word_cnt};
                                r_data     <= {bus.rx_data, r_word};
                                r_word_cnt <= r_word_cnt + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready  = w_rx_ready;
    assign bus.write     = r_write;
    assign bus.addr_in   = r_addr;
    assign bus.data      = r_data;
    assign bus.cpu_reset = r_cpu_reset;
    assign bus.done      = r_done;
    assign bus.error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
//============================================================================
// Module   : tb_imem_loader
// Brief    : Directed and random loads into two loaders (START_WORD 0 and 1)
//            sharing one byte stream, checked against a stream-level model.
// Revision : 1.0
//============================================================================
module tb_imem_loader;

    localparam int DEPTH = 128;
    localparam int SW1   = 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          idx;
    } wr_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] rx_data  = 8'd0;
    logic       rx_valid = 1'b0;

    logic [7:0] stim[$];
    wr_t        rec0[$];
    wr_t        rec1[$];
    wr_t        mq[$];
    int         cur_idx  = -1;
    int         edge_idx = -1;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    imem_loader_if bus0();
    imem_loader_if bus1();

    assign bus0.rx_data  = rx_data;
    assign bus0.rx_valid = rx_valid;
    assign bus1.rx_data  = rx_data;
    assign bus1.rx_valid = rx_valid;

    imem_loader #(.DEPTH(DEPTH), .START_WORD(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    imem_loader #(.DEPTH(DEPTH), .START_WORD(SW1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    // Stream index of the byte presented at each edge, tagged onto write pulses
    always @(posedge clk) edge_idx <= rx_valid ? cur_idx : -1;

    always @(negedge clk) begin
        if (bus0.write === 1'b1) rec0.push_back('{bus0.addr_in, bus0.data, edge_idx});
        if (bus1.write === 1'b1) rec1.push_back('{bus1.addr_in, bus1.data, edge_idx});
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected writes go to mq; result 0 = still loading, 1 = done, 2 = error
    function automatic int model_run(input int sw);
        int         len;
        int         base;
        logic [7:0] x;
        logic [31:0] w;
        mq.delete();
        if (stim.size() < 2) return 0;
        len = int'({stim[1], stim[0]});
        if (len > DEPTH - sw) return 2;
        x = 8'h00;
        for (int n = 0; n < len; n++) begin
            base = 2 + 4 * n;
            if (base + 3 >= stim.size()) return 0;
            w = {stim[base+3], stim[base+2], stim[base+1], stim[base]};
            x = x ^ stim[base] ^ stim[base+1] ^ stim[base+2] ^ stim[base+3];
            mq.push_back('{32'(sw + n), w, base + 3});
        end
        if (2 + 4 * len >= stim.size()) return 0;
        return (stim[2 + 4 * len] == x) ? 1 : 2;
    endfunction

    task automatic get_outs(input int d, output logic [31:0] o[7]);
        if (d == 0) o = '{32'(bus0.write), bus0.addr_in, bus0.data, 32'(bus0.cpu_reset),
                          32'(bus0.done), 32'(bus0.error), 32'(bus0.rx_ready)};
        else        o = '{32'(bus1.write), bus1.addr_in, bus1.data, 32'(bus1.cpu_reset),
                          32'(bus1.done), 32'(bus1.error), 32'(bus1.rx_ready)};
    endtask

    task automatic check_reset_vals(input string tag);
        logic [31:0] o[7];
        for (int d = 0; d < 2; d++) begin
            get_outs(d, o);
            chk($sformatf("%s/dut%0d/write", tag, d), o[0], 32'd0);
            chk($sformatf("%s/dut%0d/addr", tag, d), o[1], 32'd0);
            chk($sformatf("%s/dut%0d/data", tag, d), o[2], 32'd0);
            chk($sformatf("%s/dut%0d/cpu_reset", tag, d), o[3], 32'd1);
            chk($sformatf("%s/dut%0d/done", tag, d), o[4], 32'd0);
            chk($sformatf("%s/dut%0d/error", tag, d), o[5], 32'd0);
            chk($sformatf("%s/dut%0d/rx_ready", tag, d), o[6], 32'd1);
        end
    endtask

    task automatic check_dut(input string tag, input int d);
        int          res;
        wr_t         got[$];
        logic [31:0] o[7];
        res = model_run((d == 0) ? 0 : SW1);
        if (d == 0) got = rec0; else got = rec1;
        chk($sformatf("%s/dut%0d/nwrites", tag, d), 32'(got.size()), 32'(mq.size()));
        for (int i = 0; i < mq.size() && i < got.size(); i++) begin
            chk($sformatf("%s/dut%0d/w%0d_addr", tag, d, i), got[i].addr, mq[i].addr);
            chk($sformatf("%s/dut%0d/w%0d_data", tag, d, i), got[i].data, mq[i].data);
            chk($sformatf("%s/dut%0d/w%0d_byte", tag, d, i), 32'(got[i].idx), 32'(mq[i].idx));
        end
        get_outs(d, o);
        chk($sformatf("%s/dut%0d/done", tag, d), o[4], {31'd0, res == 1});
        chk($sformatf("%s/dut%0d/error", tag, d), o[5], {31'd0, res == 2});
        chk($sformatf("%s/dut%0d/cpu_reset", tag, d), o[3], {31'd0, res != 1});
        chk($sformatf("%s/dut%0d/rx_ready", tag, d), o[6], {31'd0, res == 0});
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        cur_idx  = -1;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rec0.delete();
        rec1.delete();
    endtask

    task automatic drive(input bit gaps, input int tail);
        for (int i = 0; i < stim.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                cur_idx  = -1;
                rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            rx_data  = stim[i];
            cur_idx  = i;
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        cur_idx  = -1;
        repeat (tail) @(posedge clk);
        if (tail > 0) #1;
    endtask

    task automatic set_normal(input logic [7:0] csum);
        stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h07, 8'h00, 8'h00, csum};
    endtask

    initial begin
        int         len;
        logic [7:0] x;
        logic [7:0] b;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        do_reset();

        // Normal load, no gaps: done must appear right after the checksum edge
        set_normal(8'hA3);
        drive(1'b0, 0);
        chk("norm/done_latency", {31'd0, bus0.done}, 32'd1);
        chk("norm/cpu_reset_latency", {31'd0, bus0.cpu_reset}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("norm/nwrites_const", 32'(rec0.size()), 32'd2);
        if (rec0.size() == 2) begin
            chk("norm/w0_addr_const", rec0[0].addr, 32'd0);
            chk("norm/w0_data_const", rec0[0].data, 32'h0000_0013);
            chk("norm/w1_addr_const", rec0[1].addr, 32'd1);
            chk("norm/w1_data_const", rec0[1].data, 32'h0000_07B7);
        end
        check_dut("norm", 0);
        check_dut("norm", 1);

        do_reset();
        set_normal(8'hA3);
        drive(1'b1, 3);
        check_dut("gaps", 0);
        check_dut("gaps", 1);

        do_reset();
        stim = {8'h00, 8'h00, 8'h00};
        drive(1'b1, 3);
        check_dut("empty", 0);
        check_dut("empty", 1);

        do_reset();
        stim = {8'h00, 8'h00, 8'h5A};
        drive(1'b0, 3);
        check_dut("empty_bad", 0);
        check_dut("empty_bad", 1);

        // Oversize: error the cycle after the second header byte, then deaf
        do_reset();
        stim = {8'h81, 8'h00};
        drive(1'b0, 0);
        chk("over/error_latency", {31'd0, bus0.error}, 32'd1);
        chk("over/rx_ready", {31'd0, bus0.rx_ready}, 32'd0);
        stim = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        drive(1'b0, 3);
        chk("over/nwrites", 32'(rec0.size() + rec1.size()), 32'd0);
        chk("over/error_hold", {31'd0, bus0.error}, 32'd1);
        chk("over/cpu_reset", {31'd0, bus0.cpu_reset}, 32'd1);

        do_reset();
        set_normal(8'hA2);
        drive(1'b0, 3);
        check_dut("mismatch", 0);
        check_dut("mismatch", 1);

        // Reset during the write cycle of the first word, then a full replay
        do_reset();
        stim = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
        drive(1'b0, 0);
        chk("midrst/write_before", {31'd0, bus0.write}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_vals("midrst");
        rec0.delete();
        rec1.delete();
        set_normal(8'hA3);
        drive(1'b0, 3);
        check_dut("replay", 0);
        check_dut("replay", 1);

        // Random images, including the capacity boundaries of both loaders
        for (int it = 0; it < 10; it++) begin
            do_reset();
            len = (it == 0) ? 127 : (it == 1) ? 128 : (it == 2) ? 129 : int'($urandom_range(0, 9));
            stim = {8'(len), 8'(len >> 8)};
            x = 8'h00;
            if (len <= DEPTH) begin
                for (int k = 0; k < 4 * len; k++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    stim.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
                stim.push_back(x);
            end else begin
                for (int k = 0; k < 6; k++) stim.push_back(8'($urandom));
            end
            drive(1'($urandom_range(0, 1)), 3);
            check_dut($sformatf("rand%0d", it), 0);
            check_dut($sformatf("rand%0d", it), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
